// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-master LSU arbiter.
// Holds the FSM states, the RV32 load/store funct3 codes, the captured request and the access-legality check.
package lsu_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        id;
  } lsu_req_t;

  // Illegal encodings, unsigned stores and misaligned halfword/word accesses.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    e = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (we && f3[2]) e = 1'b1;
    if ((f3[1:0] == F3_LH[1:0]) && a[0]) e = 1'b1;
    if ((f3[1:0] == F3_LW[1:0]) && (a != 2'b00)) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/lsu_arbiter_rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins a tie
// and flips to the other side after every grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // A grant is always an acceptance, so the pointer moves on every grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      r_ptr <= 1'b0;
    else if (|o_gnt)  r_ptr <= o_gnt[0];
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates core (m0) and debug/DMA (m1) load/store requests onto one LSU port,
// one transaction at a time: IDLE -> ISSUE -> [WAIT] -> RESP.
module lsu_arbiter
  import lsu_arb_pkg::*;
#(
  parameter int unsigned LD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  input  logic        m0_req_we_i,
  input  logic [2:0]  m0_req_funct3_i,
  input  logic [31:0] m0_req_addr_i,
  input  logic [31:0] m0_req_wdata_i,
  output logic        m0_rsp_valid_o,
  output logic [31:0] m0_rsp_rdata_o,
  output logic        m0_rsp_err_o,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  input  logic        m1_req_we_i,
  input  logic [2:0]  m1_req_funct3_i,
  input  logic [31:0] m1_req_addr_i,
  input  logic [31:0] m1_req_wdata_i,
  output logic        m1_rsp_valid_o,
  output logic [31:0] m1_rsp_rdata_o,
  output logic        m1_rsp_err_o,
  output logic        lsu_wren_o,
  output logic [2:0]  lsu_funct3_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  input  logic [31:0] lsu_ld_data_i,
  output logic        busy_o
);

  localparam logic [1:0] LAT = 2'(LD_LATENCY);

  arb_state_e  r_state;
  lsu_req_t    r_req;
  logic        r_err;
  logic        r_wren;
  logic [1:0]  r_cnt;
  logic [1:0]  r_rsp_vld;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic [1:0]  w_gnt;
  logic        w_acc;
  lsu_req_t    w_new;
  logic        w_new_err;
  logic        w_skip_wait;
  logic [1:0]  w_rsp_sel;

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_req  ({m1_req_valid_i, m0_req_valid_i}),
    .i_en   (r_state == S_IDLE),
    .o_gnt  (w_gnt)
  );

  assign w_acc = |w_gnt;

  always_comb begin
    if (w_gnt[1]) begin
      w_new.we     = m1_req_we_i;
      w_new.funct3 = m1_req_funct3_i;
      w_new.addr   = m1_req_addr_i;
      w_new.wdata  = m1_req_wdata_i;
      w_new.id     = 1'b1;
    end else begin
      w_new.we     = m0_req_we_i;
      w_new.funct3 = m0_req_funct3_i;
      w_new.addr   = m0_req_addr_i;
      w_new.wdata  = m0_req_wdata_i;
      w_new.id     = 1'b0;
    end
  end

  assign w_new_err   = access_err(w_new.we, w_new.funct3, w_new.addr[1:0]);
  assign w_skip_wait = r_req.we | r_err | (LAT == 2'd0);
  assign w_rsp_sel   = r_req.id ? 2'b10 : 2'b01;

  // The response register is only written on entry to RESP, so rdata stays
  // stable between response pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_req       <= '0;
      r_err       <= 1'b0;
      r_wren      <= 1'b0;
      r_cnt       <= 2'd0;
      r_rsp_vld   <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      r_wren    <= 1'b0;
      r_rsp_vld <= 2'b00;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_req   <= w_new;
            r_err   <= w_new_err;
            r_wren  <= w_new.we & ~w_new_err;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_skip_wait) begin
            r_rsp_vld   <= w_rsp_sel;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= (r_req.we | r_err) ? 32'd0 : lsu_ld_data_i;
            r_state     <= S_RESP;
          end else begin
            r_cnt   <= 2'd1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAT) begin
            r_cnt       <= 2'd0;
            r_rsp_vld   <= w_rsp_sel;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= lsu_ld_data_i;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_req_ready_o = w_gnt[0];
  assign m1_req_ready_o = w_gnt[1];

  assign m0_rsp_valid_o = r_rsp_vld[0];
  assign m1_rsp_valid_o = r_rsp_vld[1];
  assign m0_rsp_err_o   = r_rsp_vld[0] & r_rsp_err;
  assign m1_rsp_err_o   = r_rsp_vld[1] & r_rsp_err;
  assign m0_rsp_rdata_o = r_rsp_rdata;
  assign m1_rsp_rdata_o = r_rsp_rdata;

  assign lsu_wren_o    = r_wren;
  assign lsu_funct3_o  = r_req.funct3;
  assign lsu_addr_o    = r_req.addr;
  assign lsu_st_data_o = r_req.wdata;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: store, load, errors, contention, reset
// mid-operation, plus a latency sweep over four instances (LD_LATENCY 0..3).
module tb_lsu_arbiter;
  import lsu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid = 0, m0_we = 0, m1_valid = 0, m1_we = 0;
  logic [2:0]  m0_f3 = 0, m1_f3 = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, ld_data = 0;
  logic        m0_ready, m1_ready, m0_rsp, m1_rsp, m0_err, m1_err;
  logic        wren, busy;
  logic [31:0] m0_rdata, m1_rdata, lsu_addr, lsu_st;
  logic [2:0]  lsu_f3;

  int n_chk = 0;
  int n_fail = 0;

  initial forever #5 clk = ~clk;

  lsu_arbiter #(.LD_LATENCY(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_valid_i(m0_valid), .m0_req_ready_o(m0_ready), .m0_req_we_i(m0_we),
    .m0_req_funct3_i(m0_f3), .m0_req_addr_i(m0_addr), .m0_req_wdata_i(m0_wdata),
    .m0_rsp_valid_o(m0_rsp), .m0_rsp_rdata_o(m0_rdata), .m0_rsp_err_o(m0_err),
    .m1_req_valid_i(m1_valid), .m1_req_ready_o(m1_ready), .m1_req_we_i(m1_we),
    .m1_req_funct3_i(m1_f3), .m1_req_addr_i(m1_addr), .m1_req_wdata_i(m1_wdata),
    .m1_rsp_valid_o(m1_rsp), .m1_rsp_rdata_o(m1_rdata), .m1_rsp_err_o(m1_err),
    .lsu_wren_o(wren), .lsu_funct3_o(lsu_f3), .lsu_addr_o(lsu_addr),
    .lsu_st_data_o(lsu_st), .lsu_ld_data_i(ld_data), .busy_o(busy)
  );

  // Latency sweep instances: m0 issues LW only, m1 idle.
  logic        sw_valid [4];
  logic        sw_ready [4];
  logic        sw_rsp [4];
  logic [31:0] sw_rdata [4];
  logic        sw_m0_err [4], sw_m1_ready [4], sw_m1_rsp [4], sw_m1_err [4];
  logic        sw_wren [4], sw_busy [4];
  logic [31:0] sw_m1_rdata [4], sw_addr [4], sw_st [4];
  logic [2:0]  sw_f3 [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    initial sw_valid[g] = 1'b0;
    lsu_arbiter #(.LD_LATENCY(g)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_valid_i(sw_valid[g]), .m0_req_ready_o(sw_ready[g]), .m0_req_we_i(1'b0),
      .m0_req_funct3_i(F3_LW), .m0_req_addr_i(32'h10), .m0_req_wdata_i(32'h0),
      .m0_rsp_valid_o(sw_rsp[g]), .m0_rsp_rdata_o(sw_rdata[g]), .m0_rsp_err_o(sw_m0_err[g]),
      .m1_req_valid_i(1'b0), .m1_req_ready_o(sw_m1_ready[g]), .m1_req_we_i(1'b0),
      .m1_req_funct3_i(3'b000), .m1_req_addr_i(32'h0), .m1_req_wdata_i(32'h0),
      .m1_rsp_valid_o(sw_m1_rsp[g]), .m1_rsp_rdata_o(sw_m1_rdata[g]), .m1_rsp_err_o(sw_m1_err[g]),
      .lsu_wren_o(sw_wren[g]), .lsu_funct3_o(sw_f3[g]), .lsu_addr_o(sw_addr[g]),
      .lsu_st_data_o(sw_st[g]), .lsu_ld_data_i(32'(32'h1000 + g)), .busy_o(sw_busy[g])
    );
  end

  // A requester must hold valid until it is accepted.
  a_m0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m0_valid && !m0_ready) |=> m0_valid);
  a_m1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m1_valid && !m1_ready) |=> m1_valid);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int m, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (m == 0) begin
      m0_valid = v; m0_we = we; m0_f3 = f3; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_valid = v; m1_we = we; m1_f3 = f3; m1_addr = a; m1_wdata = wd;
    end
  endtask

  // Present a request and hold it until accepted; returns in cycle T+1.
  task automatic issue(input int m, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    logic ok;
    ok = 1'b0;
    drive(m, 1'b1, we, f3, a, wd);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = (m == 0) ? m0_ready : m1_ready;
      @(posedge clk); #1;
    end
    drive(m, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  logic [2:0]  e_f3 [4] = '{F3_LW, F3_SH, 3'b111, 3'b100};
  logic        e_we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] e_ad [4] = '{32'h102, 32'h101, 32'h0, 32'h0};

  initial begin
    int q[$];
    int i0, i1, ng, nr, npulse, na;
    int ta[2], tr[2];
    logic g0, g1;
    logic [31:0] rd;

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_addr", lsu_addr, 0);
    chk("rst_st_data", lsu_st, 0);
    chk("rst_funct3", 32'(lsu_f3), 0);
    chk("rst_rsp", 32'({m0_rsp, m1_rsp, m0_err, m1_err}), 0);
    chk("rst_rdata", m0_rdata, 0);
    chk("rst_ready", 32'({m0_ready, m1_ready}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single store
    issue(0, 1'b1, F3_SW, 32'h100, 32'hDEAD_BEEF);
    chk("st_wren_t1", 32'(wren), 1);
    chk("st_addr", lsu_addr, 32'h100);
    chk("st_data", lsu_st, 32'hDEAD_BEEF);
    chk("st_busy", 32'(busy), 1);
    chk("st_rsp_t1", 32'(m0_rsp), 0);
    cyc();
    chk("st_rsp_t2", 32'({m0_rsp, m1_rsp}), 32'b10);
    chk("st_wren_t2", 32'(wren), 0);
    chk("st_rdata", m0_rdata, 0);
    chk("st_err", 32'(m0_err), 0);
    cyc();
    chk("st_rsp_t3", 32'(m0_rsp), 0);
    chk("st_idle", 32'(busy), 0);

    // Load LB on m1, data valid one cycle after ISSUE
    issue(1, 1'b0, F3_LB, 32'h103, 32'h0);
    ld_data = 32'h55;
    chk("ld_wren", 32'(wren), 0);
    chk("ld_addr", lsu_addr, 32'h103);
    cyc();
    ld_data = 32'h80;
    chk("ld_rsp_t2", 32'(m1_rsp), 0);
    cyc();
    ld_data = 32'h0;
    chk("ld_rsp_t3", 32'({m0_rsp, m1_rsp}), 32'b01);
    chk("ld_rdata", m1_rdata, 32'h80);
    chk("ld_err", 32'(m1_err), 0);
    cyc();
    chk("ld_rsp_t4", 32'(m1_rsp), 0);
    chk("ld_rdata_hold", m1_rdata, 32'h80);

    // Error requests
    ld_data = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      issue(0, e_we[k], e_f3[k], e_ad[k], 32'h1234_5678);
      chk($sformatf("err%0d_wren", k), 32'(wren), 0);
      chk($sformatf("err%0d_rsp_t1", k), 32'(m0_rsp), 0);
      cyc();
      chk($sformatf("err%0d_rsp_t2", k), 32'(m0_rsp), 1);
      chk($sformatf("err%0d_err", k), 32'(m0_err), 1);
      chk($sformatf("err%0d_rdata", k), m0_rdata, 0);
      chk($sformatf("err%0d_wren_t2", k), 32'(wren), 0);
      cyc();
    end
    ld_data = 32'h0;

    // Contention: both valid from reset, four stores each
    do_reset();
    drive(0, 1'b1, 1'b1, F3_SW, 32'h200, 32'hA0);
    drive(1, 1'b1, 1'b1, F3_SW, 32'h300, 32'hB0);
    i0 = 0; i1 = 0; ng = 0; nr = 0;
    for (int c = 0; c < 200 && nr < 8; c++) begin
      @(negedge clk);
      if (m0_rsp && m1_rsp) chk("rsp_both", 1, 0);
      else if (m0_rsp || m1_rsp) begin
        if (q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk($sformatf("rsp_owner%0d", nr), 32'(m1_rsp), 32'(q.pop_front()));
        nr++;
      end
      g0 = m0_valid & m0_ready;
      g1 = m1_valid & m1_ready;
      if (g0 || g1) begin
        chk($sformatf("gnt_order%0d", ng), 32'(g1), 32'(ng % 2));
        q.push_back(int'(g1));
        ng++;
      end
      @(posedge clk); #1;
      if (g0) begin
        i0++;
        if (i0 == 4) m0_valid = 1'b0; else m0_addr = 32'(32'h200 + 4 * i0);
      end
      if (g1) begin
        i1++;
        if (i1 == 4) m1_valid = 1'b0; else m1_addr = 32'(32'h300 + 4 * i1);
      end
    end
    chk("cont_rsp_cnt", 32'(nr), 8);
    m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (3) cyc();

    // Reset during WAIT of a load; previous grant was m1, so pointer is m0 anyway,
    // bias it toward m1 first with one m0 grant.
    issue(0, 1'b1, F3_SW, 32'h0, 32'h0);
    cyc(); cyc();
    issue(0, 1'b0, F3_LW, 32'h40, 32'h0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rsp", 32'(m0_rsp), 0);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (m0_rsp || m1_rsp || wren) npulse++;
    end
    chk("mid_rst_no_rsp", 32'(npulse), 0);
    drive(0, 1'b1, 1'b0, F3_LW, 32'h44, 32'h0);
    drive(1, 1'b1, 1'b1, F3_SW, 32'h48, 32'h77);
    #1;
    chk("post_rst_ptr", 32'({m1_ready, m0_ready}), 32'b01);
    cyc();
    m0_valid = 1'b0;
    cyc();
    ld_data = 32'h1234_5678;
    cyc();
    chk("post_rst_rsp", 32'(m0_rsp), 1);
    chk("post_rst_rdata", m0_rdata, 32'h1234_5678);
    ld_data = 32'h0;
    cyc();
    chk("post_rst_m1_gnt", 32'(m1_ready), 1);
    cyc();
    m1_valid = 1'b0;
    repeat (3) cyc();

    // Latency sweep: back-to-back LW on each instance
    for (int k = 0; k < 4; k++) begin
      sw_valid[k] = 1'b1;
      na = 0; nr = 0;
      for (int c = 0; c < 40 && nr < 2; c++) begin
        #1;
        if (sw_ready[k] && na < 2) begin ta[na] = c; na++; end
        if (sw_rsp[k]) begin tr[nr] = c; rd = sw_rdata[k]; nr++; end
        @(posedge clk); #1;
        if (na == 2) sw_valid[k] = 1'b0;
      end
      sw_valid[k] = 1'b0;
      if (nr < 2 || na < 2) chk($sformatf("lat%0d_timeout", k), 32'(nr + na), 4);
      else begin
        chk($sformatf("lat%0d_rsp0", k), 32'(tr[0] - ta[0]), 32'(2 + k));
        chk($sformatf("lat%0d_b2b", k), 32'(ta[1] - tr[0]), 1);
        chk($sformatf("lat%0d_rsp1", k), 32'(tr[1] - ta[1]), 32'(2 + k));
        chk($sformatf("lat%0d_rdata", k), rd, 32'(32'h1000 + k));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
